// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

    localparam int LED_W     = 16;
    localparam int LED_DIV_W = 24;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_BLINK = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // States in which the prescaler advances the pattern.
    function automatic logic is_ticking(input state_e st);
        return (st == ST_RUN) || (st == ST_BLINK);
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Tick prescaler: counts 0..div_eff-1 with a zero divider clamped to one.
// The tick register is high exactly while the counter sits on its last value.
module led_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div_eff_s;
    logic [DIV_W-1:0] last_s;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;

    // Next counter value; en/clr describe the cycle being entered.
    always_comb begin
        div_eff_s = (div == '0) ? ONE : div;
        last_s    = div_eff_s - ONE;
        if (!en || clr) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == last_s) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end
    end

    // Counter and tick registers, tick precomputed from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= en && (cnt_nxt_s == last_s);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: command handshake, mode FSM and the run/blink/hold
// pattern datapath driving the LED vector.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int               WIDTH       = LED_W,
    parameter int               DIV_W       = LED_DIV_W,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 24'd5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_pattern,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r, next_state_s;
    mode_e            mode_r;
    logic [DIV_W-1:0] div_r;
    logic [WIDTH-1:0] pat_r;
    logic [WIDTH-1:0] led_r;
    logic             phase_r;
    logic             tick_s;
    logic             ready_s;
    logic             busy_s;
    logic             accept_s;

    assign accept_s = cfg_valid && ready_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: any accept goes through LOAD, LOAD dispatches on the mode.
    always_comb begin
        next_state_s = state_r;
        if (accept_s) begin
            next_state_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    case (mode_r)
                        MODE_OFF:   next_state_s = ST_IDLE;
                        MODE_RUN:   next_state_s = ST_RUN;
                        MODE_BLINK: next_state_s = ST_BLINK;
                        MODE_HOLD:  next_state_s = ST_HOLD;
                        default:    next_state_s = ST_IDLE;
                    endcase
                end
                default: next_state_s = state_r;
            endcase
        end
    end

    // Handshake and status decode.
    always_comb begin
        ready_s = (state_r != ST_LOAD);
        busy_s  = (state_r != ST_IDLE);
    end

    assign cfg_ready = ready_s;
    assign busy      = busy_s;

    // Command capture on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r <= MODE_OFF;
            div_r  <= DEFAULT_DIV;
            pat_r  <= '0;
        end else if (accept_s) begin
            mode_r <= mode_e'(cfg_mode);
            div_r  <= cfg_div;
            pat_r  <= cfg_pattern;
        end
    end

    // The counter restarts whenever a running state is entered from LOAD.
    led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (is_ticking(next_state_s)),
        .clr  (!is_ticking(state_r)),
        .div  (div_r),
        .tick (tick_s)
    );

    // LED drive: LOAD seeds the pattern, ticks rotate or toggle it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r   <= '0;
            phase_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    phase_r <= (mode_r == MODE_BLINK);
                    case (mode_r)
                        MODE_RUN:   led_r <= (pat_r == '0) ? LED_ONE : pat_r;
                        MODE_BLINK: led_r <= pat_r;
                        MODE_HOLD:  led_r <= pat_r;
                        default:    led_r <= '0;
                    endcase
                end
                ST_RUN: begin
                    if (tick_s) begin
                        led_r <= {led_r[WIDTH-2:0], led_r[WIDTH-1]};
                    end
                end
                ST_BLINK: begin
                    if (tick_s) begin
                        led_r   <= phase_r ? '0 : pat_r;
                        phase_r <= ~phase_r;
                    end
                end
                ST_HOLD: led_r <= led_r;
                default: led_r <= '0;
            endcase
        end
    end

    assign led  = led_r;
    assign tick = tick_s;

endmodule
